// File: rtl/z80_im2_intc_if.sv
// CPU-side bus bundle of the Z80 IM2 interrupt controller: IO strobes, address, data and nINT.
// The CPU (or bench) takes the master view, the controller takes the slave view.
interface z80_im2_intc_if;
    logic [7:0] Address;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       DataOE;
    logic       nIORQ;
    logic       nRD;
    logic       nWR;
    logic       nM1;
    logic       nINT;

    modport master (output Address, DataIn, nIORQ, nRD, nWR, nM1,
                    input  DataOut, DataOE, nINT);
    modport slave  (input  Address, DataIn, nIORQ, nRD, nWR, nM1,
                    output DataOut, DataOE, nINT);
endinterface

// File: rtl/z80_im2_intc.sv
// Z80 mode-2 interrupt controller: edge-latched requests, mask, fixed priority with nesting,
// IO-mapped registers and a per-channel vector returned during interrupt acknowledge.
module z80_im2_intc #(
    parameter int         NUM_CH  = 4,
    parameter logic [7:0] IO_BASE = 8'h04
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [NUM_CH-1:0] irq,
    z80_im2_intc_if.slave     bus
);
    typedef enum logic {AckIdle, AckActive} ackState_t;

    logic [NUM_CH-1:0] sync1Reg, sync2Reg, syncPrevReg, edgeDet;
    logic [NUM_CH-1:0] pendingReg, pendingNext;
    logic [NUM_CH-1:0] maskReg, maskNext;
    logic [NUM_CH-1:0] isrReg, isrNext;
    logic [NUM_CH-1:0] eligible, ackOneHot, eoiOneHot;
    logic [3:0]        vbaseReg, vbaseNext;
    logic [2:0]        chReg, reqCh, ackCh;
    logic              spurReg, reqValid, ackSpur, blocked;
    logic              wrPrevReg, nIntReg;
    ackState_t         stateReg, stateNext;
    logic              inWindow, inta, intaFirst, wrQual, rdQual, wrFire;
    logic [7:0]        rdData, vector;
    logic [1:0]        offset;

    assign offset   = bus.Address[1:0];
    assign inWindow = (bus.Address[7:2] == IO_BASE[7:2]);
    assign inta     = ~bus.nM1 & ~bus.nIORQ;
    assign wrQual   = ~bus.nIORQ & bus.nM1 & ~bus.nWR & inWindow;
    assign rdQual   = ~bus.nIORQ & bus.nM1 & ~bus.nRD & inWindow;
    // A write strobe held over several clocks acts only once
    assign wrFire   = wrQual & ~wrPrevReg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gChan
            assign edgeDet[gi]  = sync2Reg[gi] & ~syncPrevReg[gi];
            assign eligible[gi] = pendingReg[gi] & ~maskReg[gi];
        end
    endgenerate

    // Channel i may request only while no in-service bit at index <= i is set
    always_comb begin
        blocked   = 1'b0;
        reqValid  = 1'b0;
        reqCh     = '0;
        ackOneHot = '0;
        eoiOneHot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (isrReg[i] && !blocked) eoiOneHot[i] = 1'b1;
            blocked = blocked | isrReg[i];
            if (!blocked && !reqValid && eligible[i]) begin
                reqValid     = 1'b1;
                reqCh        = 3'(i);
                ackOneHot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) stateReg <= AckIdle;
        else         stateReg <= stateNext;
    end

    always_comb begin
        stateNext = inta ? AckActive : AckIdle;
    end

    // First acknowledge cycle uses the live winner; later cycles replay the latched one
    always_comb begin
        intaFirst = inta && (stateReg == AckIdle);
        ackCh     = (stateReg == AckActive) ? chReg : reqCh;
        ackSpur   = (stateReg == AckActive) ? spurReg : ~reqValid;
    end

    always_comb begin
        pendingNext = pendingReg;
        maskNext    = maskReg;
        isrNext     = isrReg;
        vbaseNext   = vbaseReg;
        if (wrFire) begin
            case (offset)
                2'd0:    pendingNext = pendingReg & ~bus.DataIn[NUM_CH-1:0];
                2'd1:    maskNext    = bus.DataIn[NUM_CH-1:0];
                2'd2:    vbaseNext   = bus.DataIn[7:4];
                default: isrNext     = isrReg & ~eoiOneHot;
            endcase
        end
        if (intaFirst && reqValid) begin
            pendingNext = pendingNext & ~ackOneHot;
            isrNext     = isrNext | ackOneHot;
        end
        // A fresh edge wins over a same-cycle clear
        pendingNext = pendingNext | edgeDet;
    end

    always_comb begin
        case (offset)
            2'd0:    rdData = 8'(pendingReg);
            2'd1:    rdData = 8'(maskReg);
            2'd2:    rdData = {vbaseReg, 4'h0};
            default: rdData = 8'(isrReg);
        endcase
        vector      = {vbaseReg, (ackSpur ? 3'b111 : ackCh), 1'b0};
        bus.DataOE  = nRESET & (inta | rdQual);
        bus.DataOut = 8'h00;
        if (nRESET && inta)        bus.DataOut = vector;
        else if (nRESET && rdQual) bus.DataOut = rdData;
    end

    assign bus.nINT = nIntReg;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync1Reg    <= '0;
            sync2Reg    <= '0;
            syncPrevReg <= '0;
            pendingReg  <= '0;
            maskReg     <= '1;
            isrReg      <= '0;
            vbaseReg    <= '0;
            chReg       <= '0;
            spurReg     <= 1'b0;
            wrPrevReg   <= 1'b0;
            nIntReg     <= 1'b1;
        end else begin
            sync1Reg    <= irq;
            sync2Reg    <= sync1Reg;
            syncPrevReg <= sync2Reg;
            pendingReg  <= pendingNext;
            maskReg     <= maskNext;
            isrReg      <= isrNext;
            vbaseReg    <= vbaseNext;
            wrPrevReg   <= wrQual;
            nIntReg     <= ~reqValid;
            if (intaFirst) begin
                chReg   <= reqCh;
                spurReg <= ~reqValid;
            end
        end
    end
endmodule

// File: tb/tb_z80_im2_intc.sv
// Bench for z80_im2_intc: a directed vector table, hand-built corner sequences, then random
// bus traffic checked against a register-level model of the controller.
module tb_z80_im2_intc;
    localparam int         NUM_CH  = 4;
    localparam logic [7:0] IO_BASE = 8'h04;
    localparam logic [7:0] CH_MASK = 8'h0F;

    localparam int OP_WR    = 0;
    localparam int OP_RD    = 1;
    localparam int OP_PULSE = 2;
    localparam int OP_INTA  = 3;
    localparam int OP_NINT  = 4;

    typedef struct {
        int         op;
        logic [7:0] off;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic              CLK = 1'b0;
    logic              nRESET;
    logic [NUM_CH-1:0] irq;
    z80_im2_intc_if    bus();

    z80_im2_intc #(.NUM_CH(NUM_CH), .IO_BASE(IO_BASE)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .irq    (irq),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int   nCompared   = 0;
    int   nMismatched = 0;
    vec_t tbl[$];

    // Register-level model used by the random phase
    logic [7:0] mPend, mMask, mIsr, mVbase;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic busIdle();
        bus.nIORQ   = 1'b1;
        bus.nRD     = 1'b1;
        bus.nWR     = 1'b1;
        bus.nM1     = 1'b1;
        bus.Address = 8'h00;
        bus.DataIn  = 8'h00;
    endtask

    // Strobe held over two rising edges so the one-shot behaviour is exercised
    task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK);
        bus.Address = addr;
        bus.DataIn  = data;
        bus.nIORQ   = 1'b0;
        bus.nWR     = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        busIdle();
    endtask

    task automatic ioRead(input logic [7:0] addr, output logic [7:0] data, output logic oe);
        @(negedge CLK);
        bus.Address = addr;
        bus.nIORQ   = 1'b0;
        bus.nRD     = 1'b0;
        #1;
        data = bus.DataOut;
        oe   = bus.DataOE;
        @(negedge CLK);
        busIdle();
    endtask

    task automatic intaCycle(output logic [7:0] v1, output logic [7:0] v2, output logic oe);
        @(negedge CLK);
        bus.nM1   = 1'b0;
        bus.nIORQ = 1'b0;
        #1;
        v1 = bus.DataOut;
        oe = bus.DataOE;
        @(negedge CLK);
        v2 = bus.DataOut;
        @(negedge CLK);
        busIdle();
        @(negedge CLK);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] bits);
        @(negedge CLK);
        irq = bits;
        repeat (3) @(negedge CLK);
        irq = '0;
        repeat (2) @(negedge CLK);
    endtask

    function automatic void add(input int op, input logic [7:0] off, input logic [7:0] data,
                                input logic [7:0] exp, input string name);
        vec_t v;
        v.op   = op;
        v.off  = off;
        v.data = data;
        v.exp  = exp;
        v.name = name;
        tbl.push_back(v);
    endfunction

    // Highest-priority channel allowed to interrupt, or -1
    function automatic int modelWinner();
        int lowIsr;
        int w;
        lowIsr = NUM_CH;
        w      = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (mIsr[i]) lowIsr = i;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (i < lowIsr && mPend[i] && !mMask[i]) w = i;
        return w;
    endfunction

    function automatic void modelEoi();
        int lowIsr;
        lowIsr = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (mIsr[i]) lowIsr = i;
        if (lowIsr >= 0) mIsr[lowIsr] = 1'b0;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, v1, v2;
        logic       oe;
        int         w, r, off;

        busIdle();
        irq    = '0;
        nRESET = 1'b0;
        repeat (3) @(negedge CLK);
        // Reset state, including a read strobe that must not enable the bus while in reset
        bus.Address = IO_BASE + 8'd1;
        bus.nIORQ   = 1'b0;
        bus.nRD     = 1'b0;
        #1;
        check8("reset nINT", {7'b0, bus.nINT}, 8'h01);
        check8("reset DataOE", {7'b0, bus.DataOE}, 8'h00);
        check8("reset DataOut", bus.DataOut, 8'h00);
        busIdle();
        @(negedge CLK);
        nRESET = 1'b1;
        $display("txn reset checked");

        add(OP_RD, 0, 0, 8'h00, "rst PENDING");
        add(OP_RD, 1, 0, 8'h0F, "rst MASK");
        add(OP_RD, 2, 0, 8'h00, "rst VBASE");
        add(OP_RD, 3, 0, 8'h00, "rst ISR");
        add(OP_NINT, 0, 0, 8'h01, "rst nINT");
        add(OP_WR, 1, 8'h00, 0, "unmask all");
        add(OP_WR, 2, 8'h80, 0, "vbase 80");
        add(OP_PULSE, 0, 8'h04, 0, "pulse ch2");
        add(OP_NINT, 0, 0, 8'h00, "ch2 nINT");
        add(OP_INTA, 0, 0, 8'h84, "ack ch2");
        add(OP_NINT, 0, 0, 8'h01, "after ack ch2 nINT");
        add(OP_RD, 0, 0, 8'h00, "after ack PENDING");
        add(OP_RD, 3, 0, 8'h04, "after ack ISR");
        add(OP_PULSE, 0, 8'h08, 0, "pulse ch3");
        add(OP_NINT, 0, 0, 8'h01, "ch3 blocked nINT");
        add(OP_RD, 0, 0, 8'h08, "ch3 PENDING");
        add(OP_PULSE, 0, 8'h01, 0, "pulse ch0");
        add(OP_NINT, 0, 0, 8'h00, "ch0 nests nINT");
        add(OP_INTA, 0, 0, 8'h80, "ack ch0");
        add(OP_RD, 3, 0, 8'h05, "nested ISR");
        add(OP_NINT, 0, 0, 8'h01, "nested nINT");
        add(OP_WR, 3, 8'hA5, 0, "EOI 1");
        add(OP_RD, 3, 0, 8'h04, "EOI 1 ISR");
        add(OP_NINT, 0, 0, 8'h01, "EOI 1 nINT");
        add(OP_WR, 3, 8'h00, 0, "EOI 2");
        add(OP_RD, 3, 0, 8'h00, "EOI 2 ISR");
        add(OP_NINT, 0, 0, 8'h00, "ch3 raises nINT");
        add(OP_INTA, 0, 0, 8'h86, "ack ch3");
        add(OP_WR, 3, 8'h00, 0, "EOI ch3");
        add(OP_RD, 3, 0, 8'h00, "EOI ch3 ISR");
        add(OP_NINT, 0, 0, 8'h01, "idle nINT");
        add(OP_WR, 1, 8'h0F, 0, "mask all");
        add(OP_RD, 1, 0, 8'h0F, "mask all MASK");
        add(OP_PULSE, 0, 8'h02, 0, "pulse ch1 masked");
        add(OP_RD, 0, 0, 8'h02, "masked PENDING");
        add(OP_NINT, 0, 0, 8'h01, "masked nINT");
        add(OP_WR, 1, 8'h0D, 0, "unmask ch1");
        add(OP_NINT, 0, 0, 8'h00, "unmasked nINT");
        add(OP_WR, 0, 8'h02, 0, "W1C ch1");
        add(OP_NINT, 0, 0, 8'h01, "W1C nINT");
        add(OP_RD, 0, 0, 8'h00, "W1C PENDING");
        add(OP_WR, 2, 8'h4F, 0, "vbase 4F");
        add(OP_RD, 2, 0, 8'h40, "vbase low bits");
        add(OP_INTA, 0, 0, 8'h4E, "spurious");
        add(OP_RD, 0, 0, 8'h00, "spurious PENDING");
        add(OP_RD, 3, 0, 8'h00, "spurious ISR");
        add(OP_WR, 1, 8'hF0, 0, "mask upper bits");
        add(OP_RD, 1, 0, 8'h00, "upper MASK");
        add(OP_WR, 1, 8'h0F, 0, "mask all again");
        add(OP_PULSE, 0, 8'h01, 0, "pulse ch0 masked");
        add(OP_INTA, 0, 0, 8'h4E, "spurious masked");
        add(OP_RD, 0, 0, 8'h01, "spurious keeps PENDING");
        add(OP_RD, 3, 0, 8'h00, "spurious keeps ISR");
        add(OP_WR, 0, 8'hFF, 0, "W1C all");
        add(OP_RD, 0, 0, 8'h00, "W1C all PENDING");

        foreach (tbl[k]) begin
            case (tbl[k].op)
                OP_WR:    ioWrite(IO_BASE + tbl[k].off, tbl[k].data);
                OP_RD: begin
                    ioRead(IO_BASE + tbl[k].off, d, oe);
                    check8({tbl[k].name, " data"}, d, tbl[k].exp);
                    check8({tbl[k].name, " oe"}, {7'b0, oe}, 8'h01);
                end
                OP_PULSE: pulse(tbl[k].data[NUM_CH-1:0]);
                OP_INTA: begin
                    intaCycle(v1, v2, oe);
                    check8({tbl[k].name, " vector first"}, v1, tbl[k].exp);
                    check8({tbl[k].name, " vector held"}, v2, tbl[k].exp);
                    check8({tbl[k].name, " oe"}, {7'b0, oe}, 8'h01);
                end
                default:  check8(tbl[k].name, {7'b0, bus.nINT}, tbl[k].exp);
            endcase
            $display("txn vec %0d %s", k, tbl[k].name);
        end

        // New edge on ch1 lands exactly on the first acknowledge cycle of ch1
        ioWrite(IO_BASE + 8'd1, 8'h0D);
        pulse(4'b0010);
        check8("simul pre nINT", {7'b0, bus.nINT}, 8'h00);
        @(negedge CLK);
        irq = 4'b0010;
        @(negedge CLK);
        @(negedge CLK);
        bus.nM1   = 1'b0;
        bus.nIORQ = 1'b0;
        #1;
        check8("simul vector first", bus.DataOut, 8'h42);
        @(negedge CLK);
        check8("simul vector held", bus.DataOut, 8'h42);
        @(negedge CLK);
        busIdle();
        irq = '0;
        repeat (3) @(negedge CLK);
        ioRead(IO_BASE, d, oe);
        check8("simul PENDING", d, 8'h02);
        ioRead(IO_BASE + 8'd3, d, oe);
        check8("simul ISR", d, 8'h02);
        check8("simul nINT held", {7'b0, bus.nINT}, 8'h01);
        ioWrite(IO_BASE + 8'd3, 8'h00);
        check8("simul nINT after EOI", {7'b0, bus.nINT}, 8'h00);
        intaCycle(v1, v2, oe);
        check8("simul re-ack", v1, 8'h42);
        ioWrite(IO_BASE + 8'd3, 8'h00);
        check8("simul final nINT", {7'b0, bus.nINT}, 8'h01);
        $display("txn simultaneous edge/ack sequence");

        // Asynchronous reset in the middle of an acknowledge
        pulse(4'b0010);
        @(negedge CLK);
        bus.nM1   = 1'b0;
        bus.nIORQ = 1'b0;
        @(negedge CLK);
        #2;
        nRESET = 1'b0;
        #1;
        check8("inta reset DataOE", {7'b0, bus.DataOE}, 8'h00);
        check8("inta reset nINT", {7'b0, bus.nINT}, 8'h01);
        check8("inta reset DataOut", bus.DataOut, 8'h00);
        @(negedge CLK);
        busIdle();
        @(negedge CLK);
        nRESET = 1'b1;
        ioRead(IO_BASE + 8'd1, d, oe);
        check8("post reset MASK", d, 8'h0F);
        ioRead(IO_BASE, d, oe);
        check8("post reset PENDING", d, 8'h00);
        ioRead(IO_BASE + 8'd3, d, oe);
        check8("post reset ISR", d, 8'h00);
        $display("txn reset during acknowledge");

        mPend  = 8'h00;
        mMask  = CH_MASK;
        mIsr   = 8'h00;
        mVbase = 8'h00;
        for (int n = 0; n < 160; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1: begin
                    d = 8'($urandom_range(1, 15));
                    pulse(d[NUM_CH-1:0]);
                    mPend = mPend | (d & CH_MASK);
                    $display("txn rnd %0d pulse 0x%02h", n, d);
                end
                2, 3: begin
                    off = int'($urandom_range(0, 3));
                    d   = 8'($urandom);
                    ioWrite(IO_BASE + 8'(off), d);
                    case (off)
                        0:       mPend  = mPend & ~d;
                        1:       mMask  = d & CH_MASK;
                        2:       mVbase = d & 8'hF0;
                        default: modelEoi();
                    endcase
                    $display("txn rnd %0d write off %0d data 0x%02h", n, off, d);
                end
                4, 5: begin
                    off = int'($urandom_range(0, 3));
                    ioRead(IO_BASE + 8'(off), d, oe);
                    case (off)
                        0:       check8("rnd read PENDING", d, mPend);
                        1:       check8("rnd read MASK", d, mMask);
                        2:       check8("rnd read VBASE", d, mVbase);
                        default: check8("rnd read ISR", d, mIsr);
                    endcase
                    check8("rnd read oe", {7'b0, oe}, 8'h01);
                    $display("txn rnd %0d read off %0d data 0x%02h", n, off, d);
                end
                6, 7: begin
                    w = modelWinner();
                    intaCycle(v1, v2, oe);
                    if (w < 0) d = mVbase | 8'h0E;
                    else       d = mVbase | 8'(w * 2);
                    check8("rnd vector first", v1, d);
                    check8("rnd vector held", v2, d);
                    if (w >= 0) begin
                        mPend[w] = 1'b0;
                        mIsr[w]  = 1'b1;
                    end
                    $display("txn rnd %0d inta vector 0x%02h", n, v1);
                end
                8: begin
                    ioWrite(IO_BASE + 8'd3, 8'($urandom));
                    modelEoi();
                    $display("txn rnd %0d eoi", n);
                end
                default: begin
                    off = int'($urandom_range(0, 3));
                    ioWrite(IO_BASE + 8'd4 + 8'(off), 8'($urandom));
                    ioRead(IO_BASE + 8'd4 + 8'(off), d, oe);
                    check8("rnd out-of-window oe", {7'b0, oe}, 8'h00);
                    $display("txn rnd %0d out-of-window access off %0d", n, off);
                end
            endcase
            check8("rnd nINT", {7'b0, bus.nINT}, (modelWinner() < 0) ? 8'h01 : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/z80_im2_intc.md
Name: z80_im2_intc

Overview:
- Parametrised Z80 mode-2 interrupt controller for the host board.
- Replaces the single hard-wired key-to-nINT path and the fixed 0x80 acknowledge vector.
- Collects up to 8 request lines, latches rising edges, and applies mask and fixed priority with nesting.
- Drives nINT and supplies a per-channel IM2 vector during the interrupt-acknowledge cycle; its registers are IO-mapped on the CPU bus.

Parameters:
NUM_CH, 4, number of request channels (1..8); channel 0 has the highest priority
IO_BASE, 8'h04, upper IO address byte (Address = A[15:8]) of the 4-register window; must be a multiple of 4

Ports:
CLK  in  1  CPU clock; the only clock
nRESET  in  1  asynchronous active-low reset
irq  in  NUM_CH  raw asynchronous requests, active-high (invert keys at the top level)
Address  in  8  A[15:8] from the CPU
DataIn  in  8  CPU data bus, read side
DataOut  out  8  data presented to the CPU
DataOE  out  1  high when DataOut must drive the bus (top level builds the tristate)
nIORQ  in  1  CPU IO request, active low
nRD  in  1  CPU read, active low
nWR  in  1  CPU write, active low
nM1  in  1  CPU M1, active low
nINT  out  1  interrupt request to the CPU, active low, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - pending=0, isr=0, mask=all ones (all channels masked), vbase=0.
  - nINT=1, DataOE=0, DataOut=0.
- Input conditioning:
  - Each irq bit passes a 2-FF synchroniser, then a rising-edge detector.
  - A detected edge sets pending[i] the next cycle.
  - Masked channels still latch pending.
- Register map (offset = Address - IO_BASE):
  - 0: PENDING. Read = pending; write 1 clears the bit (W1C).
  - 1: MASK. R/W; bit=1 masks the channel.
  - 2: VBASE. R/W; only bits [7:4] are stored, reads return {vbase[7:4],4'b0}.
  - 3: EOI. Write clears the highest-priority set isr bit (data ignored); reads return isr.
  - Bits >= NUM_CH read 0 and ignore writes.
- IO access timing:
  - Write: decoded when nIORQ=0, nM1=1, nWR=0 and Address is in the window.
  - The write acts once, on the first CLK edge where the qualified strobe is seen (one-shot edge of the strobe); the strobe must drop before another write is accepted.
  - Read: DataOE=1 combinationally while nIORQ=0, nM1=1, nRD=0 and in window.
- Request logic:
  - eligible = pending & ~mask.
  - req = lowest-index eligible channel whose index is below the lowest-index set isr bit; with isr=0, any eligible channel qualifies.
  - nINT <= ~(req valid), registered, updated every cycle.
- Acknowledge:
  - INTA = nM1=0 and nIORQ=0.
  - On the first INTA cycle, the winning channel ch is latched.
  - On that cycle pending[ch] is cleared and isr[ch] is set; nINT goes high the next cycle unless another higher-priority request exists.
  - While INTA holds: DataOE=1, DataOut={vbase[7:4], ch[2:0], 1'b0}.
  - The latched value is held until INTA ends, so it stays stable even if requests change.
  - Spurious INTA (no valid req): vector {vbase[7:4],3'b111,0}; no state change.
- Simultaneous events:
  - A new edge on ch in the same cycle as its acknowledge leaves pending[ch]=1.
  - A new edge in the same cycle as a W1C of the same bit leaves pending=1.
  - EOI and acknowledge in the same cycle cannot occur (bus cycles are exclusive); no priority rule is needed.
- Reset mid-INTA or mid-write: all state returns to reset values immediately; DataOE drops asynchronously.

Test Plan:
- Reset, NUM_CH=4: write MASK=0, pulse irq[2] for 3 cycles → nINT low within 4 CLKs. INTA with VBASE=0x80 → DataOut=0x84, DataOE=1. Then nINT=1, PENDING reads 0, EOI offset reads 0x04.
- Nesting:
  - Ack ch2, then pulse irq[3] → nINT stays high.
  - Pulse irq[0] → nINT low; INTA vector 0x80; isr=0x05.
  - EOI write → isr=0x04. Second EOI → isr=0; ch3 pending now raises nINT.
- Mask: MASK=0x0F, pulse irq[1] → PENDING=0x02, nINT stays 1. Write MASK=0x0D → nINT low next cycles. W1C PENDING 0x02 before INTA → nINT returns high.
- Simultaneous: irq[1] edge lands on the INTA-first cycle for ch1 → after the ack PENDING=0x02 and isr=0x02; nINT stays high until EOI, then goes low.
- Spurious: force INTA with nothing eligible, VBASE=0x40 → DataOut=0x4E; pending and isr unchanged.
- Async reset asserted during an active INTA → DataOE=0, nINT=1, MASK reads 0x0F after release.
